// File: rtl/fetch_unit.sv
// Instruction fetch unit: two-state FETCH/EXEC sequencer that requests one word at a time
// from instruction memory, holds it for the decoder and resolves the next PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        Branch,
    input  logic        branch_taken,
    input  logic [31:0] jr_target
);

    typedef enum logic [0:0] {StFetch, StExec} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] branch_off;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    // Priority: JR over J over taken branch; result is always word aligned.
    always_comb begin
        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (JumpReg) begin
            next_pc_raw = jr_target;
        end else if (Jump) begin
            next_pc_raw = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && branch_taken) begin
            next_pc_raw = pc_plus4 + branch_off;
        end else begin
            next_pc_raw = pc_plus4;
        end
        next_pc = {next_pc_raw[31:2], 2'b00};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Request is masked while reset is held so an abandoned fetch is dropped at once.
    assign imem_req    = (state_q == StFetch) && !reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == StExec);
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a driver plays memory and decoder, a monitor checks
// every instruction the DUT presents against a queue filled from a PC-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        Jump;
    logic        JumpReg;
    logic        Branch;
    logic        branch_taken;
    logic [31:0] jr_target;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .stall       (stall),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .Branch      (Branch),
        .branch_taken(branch_taken),
        .jr_target   (jr_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_pc;
    logic [31:0] model_instr;
    logic        mon_prev = 1'b0;
    exp_t        mon_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference next-PC rule, written straight from the ISA description.
    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                             input logic j, input logic jr, input logic br,
                                             input logic bt, input logic [31:0] jrt);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = cur_pc + 32'd4;
        off = 32'($signed(ins[15:0])) * 32'd4;
        if (jr)             return jrt & 32'hFFFF_FFFC;
        else if (j)         return {p4[31:28], ins[25:0], 2'b00};
        else if (br && bt)  return p4 + off;
        else                return p4;
    endfunction

    task automatic do_fetch(input int wcyc, input logic [31:0] data);
        int guard = 0;
        imem_ack = 1'b0;
        while (!imem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("fetch_req_seen", 32'(imem_req), 32'd1);
        for (int w = 0; w < wcyc; w++) begin
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, model_pc);
            imem_rdata = $urandom;
            @(negedge clk);
        end
        chk("ack_addr", imem_addr, model_pc);
        imem_ack    = 1'b1;
        imem_rdata  = data;
        model_instr = data;
        exp_q.push_back('{pc: model_pc, instr: data});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic do_exec(input int stall_n, input logic j, input logic jr, input logic br,
                           input logic bt, input logic [31:0] jrt);
        chk("exec_valid", 32'(instr_valid), 32'd1);
        Jump = j; JumpReg = jr; Branch = br; branch_taken = bt; jr_target = jrt;
        for (int s = 0; s < stall_n; s++) begin
            stall      = 1'b1;
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clk);
        end
        stall      = 1'b0;
        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        model_pc   = ref_next(model_pc, model_instr, j, jr, br, bt, jrt);
        @(negedge clk);
        imem_ack = 1'b0;
        Jump = 1'b0; JumpReg = 1'b0; Branch = 1'b0; branch_taken = 1'b0;
        chk("after_exec_valid", 32'(instr_valid), 32'd0);
        chk("next_pc", pc, model_pc);
        chk("next_addr", imem_addr, model_pc);
    endtask

    // Monitor: pops on each new instruction, then checks hold behaviour while it stays valid.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev = 1'b0;
            end else begin
                if (instr_valid && !mon_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_instr: got pc 0x%08h, nothing expected", pc);
                    end else begin
                        mon_cur = exp_q.pop_front();
                        chk("mon_pc", pc, mon_cur.pc);
                        chk("mon_instr", instr, mon_cur.instr);
                        chk("mon_pc_plus4", pc_plus4, mon_cur.pc + 32'd4);
                        chk("mon_req_low", 32'(imem_req), 32'd0);
                    end
                end else if (instr_valid) begin
                    chk("hold_pc", pc, mon_cur.pc);
                    chk("hold_instr", instr, mon_cur.instr);
                    chk("hold_req_low", 32'(imem_req), 32'd0);
                end
                mon_prev = instr_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        Jump = 1'b0; JumpReg = 1'b0; Branch = 1'b0; branch_taken = 1'b0; jr_target = 32'd0;
        model_pc = RST_PC; model_instr = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RST_PC);

        // Sequential fetches, zero and three wait cycles, with a 5-cycle stall.
        do_fetch(0, 32'h2008_0005); do_exec(0, 0, 0, 0, 0, 0);
        do_fetch(3, 32'h2008_0005); do_exec(5, 0, 0, 0, 0, 0);

        // Backward branch taken and not taken from 0x00400010.
        do_fetch(1, $urandom); do_exec(0, 0, 1, 0, 0, 32'h0040_0010);
        do_fetch(0, 32'h1109_FFFC); do_exec(0, 0, 0, 1, 1, 0);
        chk("branch_taken_pc", model_pc, 32'h0040_0004);
        do_fetch(0, $urandom); do_exec(0, 0, 1, 0, 0, 32'h0040_0010);
        do_fetch(2, 32'h1109_FFFC); do_exec(1, 0, 0, 1, 0, 0);

        // Jump, then JR overriding J with a misaligned target.
        do_fetch(0, $urandom); do_exec(0, 0, 1, 0, 0, 32'h0040_0020);
        do_fetch(0, 32'h0C10_0040); do_exec(0, 1, 0, 0, 0, 0);
        do_fetch(0, 32'h0C10_0040); do_exec(0, 1, 1, 0, 0, 32'h0040_0207);

        // Address wrap from the top of memory.
        do_fetch(0, $urandom); do_exec(0, 0, 1, 0, 0, 32'hFFFF_FFFC);
        do_fetch(0, $urandom); do_exec(0, 0, 0, 0, 0, 0);
        do_fetch(0, $urandom); do_exec(0, 0, 0, 0, 0, 0);

        // Reset while a fetch at 0x00400040 is outstanding.
        do_fetch(0, $urandom); do_exec(0, 0, 1, 0, 0, 32'h0040_0040);
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        model_pc = RST_PC;
        @(negedge clk);
        chk("post_rst_addr", imem_addr, RST_PC);
        do_fetch(2, 32'h2008_0005); do_exec(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            logic [2:0] sel;
            sel = 3'($urandom_range(0, 7));
            do_fetch(int'($urandom_range(0, 3)), $urandom);
            do_exec(int'($urandom_range(0, 3)), sel[0], sel[1] & sel[2], sel[2],
                    1'($urandom), $urandom);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
